parallax_scroll_ctrl: RTL
=========================

Name: parallax_scroll_ctrl

Overview:
- Wishbone-slave controller that configures and sequences the parallax video generator.
- Holds per-layer scroll speeds written by the PicoRV32.
- Advances per-layer scroll offsets once per frame, on the active edge of the generator's vsync.
- Raises a frame interrupt. Sits inside the wrapper between the Wishbone bus and the parallax core; outputs feed the core's offset and enable inputs.

Parameters:
- ADDR_BASE, 32'h3000_0000, Wishbone window base; bits [31:8] are compared.
- OFS_W, 10, width of each layer offset in pixels; wraps modulo 2^OFS_W.
- VSYNC_ACTIVE, 1'b0, level of vsync_i during the sync pulse.

Ports:
- clk  in  1  system clock (wb_clk_i in the wrapper)
- reset_n  in  1  synchronous, active-low reset
- wbs_stb_i  in  1  Wishbone strobe
- wbs_cyc_i  in  1  Wishbone cycle
- wbs_we_i  in  1  Wishbone write enable
- wbs_sel_i  in  4  byte selects
- wbs_dat_i  in  32  write data
- wbs_adr_i  in  32  byte address
- wbs_ack_o  out  1  acknowledge
- wbs_dat_o  out  32  read data
- vsync_i  in  1  vsync from the parallax core (same clock domain)
- layer_ofs_o  out  4*OFS_W  layer n offset at bits [n*OFS_W +: OFS_W]
- layer_en_o  out  4  per-layer enable, from CTRL[7:4]
- irq_o  out  1  frame interrupt, level

Behaviour:
- Reset (reset_n=0 at a clk edge): all registers, offsets, frame counter, pending flag, ack and read data go to 0. A bus cycle in flight is dropped with no ack.
- Address hit: cyc&stb and wbs_adr_i[31:8]==ADDR_BASE[31:8]. Register index is adr[4:2].
- Registers:
  - 0 CTRL: [0] run, [1] irq_en, [7:4] layer_en.
  - 1 STATUS: [0] frame pending (write 1 to clear), [31:16] frame counter (read-only).
  - 2–5 SPEED0..3: [7:0] signed pixels per frame.
  - 6 OFSCLR: write-only; writing 1 to bit n zeroes offset n; reads 0.
  - 7: reserved; reads 0, writes ignored.
- Byte lanes: writes honour wbs_sel_i per byte. Read-only fields are ignored on write.
- Handshake:
  - wbs_ack_o rises 1 cycle after a hit and stays high exactly 1 cycle.
  - wbs_dat_o is valid in the ack cycle and is 0 otherwise.
  - A hit while ack=1 is not re-acked. Each transfer takes 2 cycles minimum, and the master must drop stb after ack.
  - The write takes effect at the ack edge.
  - A non-hit produces no ack.
- Frame edge: vs_q samples vsync_i every cycle. Edge = (vsync_i==VSYNC_ACTIVE) && (vs_q!=VSYNC_ACTIVE). The edge is visible 1 cycle after vsync_i asserts.
- On an edge:
  - Frame counter increments (16-bit wrap) regardless of run.
  - Pending is set.
  - If run=1: offset_n <= offset_n + sign_extend(spd_act_n) mod 2^OFS_W, and spd_act_n <= SPEED_n register.
  - Result: a SPEED write affects the increment of the second edge after the write (double-buffered shadow).
- run=0 on an edge: offsets and shadow speeds hold; counter and pending still update.
- Simultaneous events:
  - Pending set and a write-1 clear in the same cycle: set wins.
  - OFSCLR and an edge increment in the same cycle: clear wins (offset = 0).
  - A SPEED write in the edge cycle: the shadow loads the old value.
- irq_o = pending & irq_en, registered; it changes 1 cycle after its cause.
- Wrap: offset 1023 + 1 = 0; offset 0 + (-1) = 1023 for OFS_W=10.
- layer_en_o and layer_ofs_o are driven directly from registers; no combinational path from the bus.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles with cyc/stb asserted -> ack=0, dat=0, irq_o=0, layer_ofs_o=0. Read STATUS after release -> 0.
- Bus handshake: write CTRL=0x0000_00F3 at base+0x00, then read it back -> ack exactly 1 cycle after each stb, read returns 0xF3, layer_en_o=4'hF. Access at base+0x100 -> no ack within 8 cycles.
- Speed shadowing: SPEED0=0x05, run=1, then 3 vsync pulses -> offset0 = 0, 5, 10 after edges 1, 2, 3. Write SPEED0=0xFE before edge 4 -> offset0 = 15 after edge 4, then 13 after edge 5.
- Wrap: OFSCLR bit1, SPEED1=0xFF (-1), run=1, then 2 edges -> offset1 = 0, then 1023. Set SPEED1=0x01 and run to 1023 -> next increment gives 0.
- IRQ: irq_en=1, edge -> irq_o high 2 cycles after vsync asserts; STATUS[31:16] increments by 1. Write-1 clear coinciding with the next edge -> pending stays 1.
- Reset mid-run: reset_n=0 during a vsync pulse with offsets nonzero -> all outputs 0 next cycle. No edge is counted when reset_n is released while vsync_i is still active; the next edge is counted after vsync deasserts and reasserts.

Source files
------------

// File: rtl/parallax_scroll_ctrl.sv
`default_nettype none
// ============================================================================
// parallax_scroll_ctrl : Wishbone register block that sequences per-layer scroll
// offsets once per vsync frame. Rev 1.0
// ============================================================================
module parallax_scroll_ctrl #(
  parameter logic [31:0] ADDR_BASE    = 32'h3000_0000,
  parameter int          OFS_W        = 10,
  parameter logic        VSYNC_ACTIVE = 1'b0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               wbs_stb_i,
  input  logic               wbs_cyc_i,
  input  logic               wbs_we_i,
  input  logic [3:0]         wbs_sel_i,
  input  logic [31:0]        wbs_dat_i,
  input  logic [31:0]        wbs_adr_i,
  output logic               wbs_ack_o,
  output logic [31:0]        wbs_dat_o,
  input  logic               vsync_i,
  output logic [4*OFS_W-1:0] layer_ofs_o,
  output logic [3:0]         layer_en_o,
  output logic               irq_o
);

  logic             ack_q, ack_d;
  logic [31:0]      dat_q, dat_d;
  logic [7:0]       ctrl_q, ctrl_d;
  logic             pend_q, pend_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             vs_q, vs_d;
  logic             irq_q, irq_d;
  logic [7:0]       spd_q [4];
  logic [7:0]       spd_d [4];
  logic [7:0]       act_q [4];
  logic [7:0]       act_d [4];
  logic [OFS_W-1:0] ofs_q [4];
  logic [OFS_W-1:0] ofs_d [4];

  logic        hit, access, wr, frame_edge;
  logic [2:0]  idx;
  logic [31:0] rdata;
  logic        unused_bits;

  assign hit        = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == ADDR_BASE[31:8]);
  assign access     = hit & ~ack_q;
  assign wr         = access & wbs_we_i & wbs_sel_i[0];
  assign idx        = wbs_adr_i[4:2];
  assign frame_edge = (vsync_i == VSYNC_ACTIVE) && (vs_q != VSYNC_ACTIVE);
  assign unused_bits = ^{wbs_adr_i[7:5], wbs_adr_i[1:0], wbs_sel_i[3:1], wbs_dat_i[31:8]};

  always_comb begin
    rdata = 32'h0;
    case (idx)
      3'd0: rdata = {24'h0, ctrl_q};
      3'd1: rdata = {cnt_q, 15'h0, pend_q};
      3'd2: rdata = {24'h0, spd_q[0]};
      3'd3: rdata = {24'h0, spd_q[1]};
      3'd4: rdata = {24'h0, spd_q[2]};
      3'd5: rdata = {24'h0, spd_q[3]};
      default: rdata = 32'h0;
    endcase
  end

  always_comb begin
    ack_d  = access;
    dat_d  = access ? rdata : 32'h0;
    ctrl_d = ctrl_q;
    pend_d = pend_q;
    cnt_d  = cnt_q;
    vs_d   = vsync_i;
    irq_d  = pend_q & ctrl_q[1];
    for (int i = 0; i < 4; i++) begin
      spd_d[i] = spd_q[i];
      act_d[i] = act_q[i];
      ofs_d[i] = ofs_q[i];
    end

    if (frame_edge) begin
      cnt_d  = cnt_q + 16'd1;
      pend_d = 1'b1;
      if (ctrl_q[0]) begin
        for (int i = 0; i < 4; i++) begin
          ofs_d[i] = ofs_q[i] + OFS_W'($signed(act_q[i]));
          act_d[i] = spd_q[i];
        end
      end
    end

    // Bus writes land after the frame update so OFSCLR beats the increment,
    // while a clear of pending loses to a coincident set.
    if (wr) begin
      case (idx)
        3'd0: ctrl_d = wbs_dat_i[7:0] & 8'hF3;
        3'd1: if (wbs_dat_i[0] && !frame_edge) pend_d = 1'b0;
        3'd6: begin
          for (int i = 0; i < 4; i++) begin
            if (wbs_dat_i[i]) ofs_d[i] = '0;
          end
        end
        default: begin
          for (int i = 0; i < 4; i++) begin
            if (idx == 3'(i + 2)) spd_d[i] = wbs_dat_i[7:0];
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ack_q  <= 1'b0;
      dat_q  <= 32'h0;
      ctrl_q <= 8'h0;
      pend_q <= 1'b0;
      cnt_q  <= 16'h0;
      vs_q   <= VSYNC_ACTIVE;
      irq_q  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        spd_q[i] <= 8'h0;
        act_q[i] <= 8'h0;
        ofs_q[i] <= '0;
      end
    end else begin
      ack_q  <= ack_d;
      dat_q  <= dat_d;
      ctrl_q <= ctrl_d;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      vs_q   <= vs_d;
      irq_q  <= irq_d;
      for (int i = 0; i < 4; i++) begin
        spd_q[i] <= spd_d[i];
        act_q[i] <= act_d[i];
        ofs_q[i] <= ofs_d[i];
      end
    end
  end

  assign wbs_ack_o  = ack_q;
  assign wbs_dat_o  = dat_q;
  assign layer_en_o = ctrl_q[7:4];
  assign irq_o      = irq_q;

  for (genvar g = 0; g < 4; g++) begin : g_ofs
    assign layer_ofs_o[g*OFS_W +: OFS_W] = ofs_q[g];
  end

endmodule
`default_nettype wire
